// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_uart_tx : memory-mapped UART transmitter (TXDATA/STATUS + FIFO). |
// | Define UART_TX_PARITY_EN for an even-parity bit. Rev 1.0             |
// +----------------------------------------------------------------------+
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int            AW          = $clog2(FIFO_DEPTH);
  localparam int            BW          = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic PARITY_FLAG = 1'b0;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       hit, wr_data, wr_stat, full, empty, busy, push, pop, baud_zero;
  logic [7:0] head;
  logic       unused_inputs;

  assign unused_inputs = ^{we[3:1], a[1:0], wd[31:8]};

  assign hit       = (a[31:3] == BASE_ADDR[31:3]);
  assign wr_data   = hit && !a[2] && we[0];
  assign wr_stat   = hit &&  a[2] && we[0];
  assign full      = (count_q == FIFO_FULL);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE);
  // Full is judged on the registered count, so a same-edge pop never rescues a write.
  assign push      = wr_data && !full;
  assign head      = mem_q[rptr_q];
  assign baud_zero = (baud_q == '0);

  assign rd = (hit && a[2]) ? {27'b0, PARITY_FLAG, ovf_q, busy, empty, full} : 32'b0;
  assign tx = tx_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wd[7:0];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_data && full)          ovf_d = 1'b1;
    else if (wr_stat && wd[3])    ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_zero ? BAUD_RELOAD : baud_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = BAUD_RELOAD;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (baud_zero) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_zero) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_zero) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_zero) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line stays glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmio_uart_tx : scoreboard bench, line-level frame decoder.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] STAT  = 32'h1000_0004;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  we;
  logic [31:0] a, wd, rd;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd), .tx(tx)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         model_count = 0;
  logic       model_ovf   = 1'b0;
  int         high_run    = 0;
  int         last_gap    = -1;
  int         frames_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy_e);
    return {27'b0, PAR, model_ovf, busy_e, model_count == 0, model_count == DEPTH};
  endfunction

  // Expected line waveform, one entry per clock: start, LSB-first data, [parity], stop.
  function automatic logic [63:0] frame_of(input logic [7:0] b);
    logic [63:0] v;
    logic        bits [NBITS];
    v       = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    bits[NBITS-1] = 1'b1;
    for (int i = 0; i < NBITS; i++)
      for (int k = 0; k < CPB; k++) v[i*CPB+k] = bits[i];
    return v;
  endfunction

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
    @(negedge clk);
    a = addr; wd = data; we = wen;
    @(posedge clk);
    if ((addr >> 3) == (BASE >> 3) && wen[0]) begin
      if (!addr[2]) begin
        if (model_count == DEPTH) model_ovf = 1'b1;
        else begin
          exp_q.push_back(data[7:0]);
          model_count++;
        end
      end else if (data[3]) begin
        model_ovf = 1'b0;
      end
    end
    #1;
    we = '0; a = STAT; wd = '0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (cyc < 5000 && !(exp_q.size() == 0 && rd[2] == 1'b0 && rd[1] == 1'b1)) begin
      sample();
      cyc++;
    end
    check(name, 64'(cyc < 5000), 64'd1);
  endtask

  // Monitor: decodes every frame on tx and compares it with the scoreboard head.
  initial begin : monitor
    logic [63:0] got;
    logic [7:0]  e;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) continue;
      if (tx !== 1'b0) begin
        high_run++;
      end else begin
        last_gap = high_run;
        model_count--;
        got      = '0;
        got[0]   = tx;
        aborted  = 1'b0;
        for (int j = 1; j < FRAME_CYC; j++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          got[j] = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected no frame", got);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("frame_%02h", e), got, frame_of(e));
          end
          frames_done++;
        end
        high_run = 0;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          bc;
    int          n;
    logic [31:0] ja;
    rst_n = 1'b0; we = '0; a = STAT; wd = '0;
    repeat (3) @(posedge clk);
    sample();
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_status_in_reset", 64'(rd), 64'(exp_status(1'b0)));
    rst_n = 1'b1;
    sample();
    check("status_after_reset", 64'(rd), 64'(exp_status(1'b0)));

    // Single byte: latency, waveform and busy length.
    store(BASE, 32'h0000_00A5, 4'b0001);
    sample();
    check("lat_tx_before_pop", 64'(tx), 64'd1);
    check("lat_status_queued", 64'(rd), 64'(exp_status(1'b0)));
    sample();
    check("lat_tx_start", 64'(tx), 64'd0);
    check("lat_status_busy", 64'(rd), 64'(exp_status(1'b1)));
    bc = 1;
    while (rd[2] && bc < 200) begin
      sample();
      if (rd[2]) bc++;
    end
    check("busy_cycles", 64'(bc), 64'(FRAME_CYC));
    drain("drain_single");

    // Overflow: one in flight, eight queued, the tenth is dropped.
    store(BASE, 32'h11, 4'b0001);
    sample(); sample();
    for (int i = 0; i < 9; i++) store(BASE, 32'h20 + 32'(i), 4'b0001);
    sample();
    check("ovf_status", 64'(rd), 64'(exp_status(1'b1)));
    check("ovf_status_literal", 64'(rd), 64'(32'h0000_000D | (32'(PAR) << 4)));
    store(STAT, 32'h8, 4'b0001);
    sample();
    check("ovf_cleared", 64'(rd), 64'(exp_status(1'b1)));
    drain("drain_ovf");

    // Back-to-back frames, then the parity test byte.
    store(BASE, 32'h01, 4'b0001);
    store(BASE, 32'h80, 4'b0001);
    store(BASE, 32'h07, 4'b0001);
    drain("drain_b2b");
    check("b2b_gap", 64'(last_gap), 64'd1);

    // Decode: out-of-window and non-lane-0 stores are ignored.
    store(32'h1000_0008, 32'h55, 4'b0001);
    store(BASE, 32'h66, 4'b0010);
    repeat (20) begin
      sample();
      if (tx !== 1'b1) check("decode_tx_idle", 64'(tx), 64'd1);
    end
    check("decode_status", 64'(rd), 64'(exp_status(1'b0)));
    a = 32'h2000_0004; #1;
    check("decode_rd_miss", 64'(rd), 64'd0);
    a = BASE; #1;
    check("decode_rd_txdata", 64'(rd), 64'd0);
    a = STAT;

    // Asynchronous reset in the middle of a frame.
    store(BASE, 32'h3C, 4'b0001);
    repeat (12) sample();
    check("midframe_busy", 64'(rd[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", 64'(tx), 64'd1);
    exp_q.delete();
    model_count = 0;
    model_ovf   = 1'b0;
    check("async_reset_status", 64'(rd), 64'(exp_status(1'b0)));
    repeat (2) sample();
    rst_n = 1'b1;
    sample();
    check("status_after_midframe_reset", 64'(rd), 64'(exp_status(1'b0)));
    repeat (FRAME_CYC + 2) sample();

    // Randomized bursts with interleaved ignored accesses.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 11));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0: begin
              ja = $urandom;
              if ((ja >> 3) == (BASE >> 3)) ja[31] = ~ja[31];
              store(ja, $urandom, 4'b0001);
            end
            1:       store(BASE, $urandom, 4'($urandom) & 4'b1110);
            default: store(STAT, $urandom & 32'hFFFF_FFF7, 4'b0001);
          endcase
        end
        store(BASE, $urandom, 4'b0001 | (4'($urandom) & 4'b1110));
      end
      sample();
      check($sformatf("rand_ovf_%0d", r), 64'(rd[3]), 64'(model_ovf));
      store(STAT, 32'h8, 4'b0001);
      drain($sformatf("rand_drain_%0d", r));
      check($sformatf("rand_idle_status_%0d", r), 64'(rd), 64'(exp_status(1'b0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
